// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide memory controller between two requesters (MEM stage,
// instruction fetch) and a single-port external RAM.
//
// Handshake: a requester raises *_req and holds its address/data stable until
// the matching *_grant is seen high. *_grant is combinational, and the access
// is taken at the rising edge of a cycle in which req and grant are both high.
// Read bytes come back three cycles after the grant, as a one-cycle
// *_data_valid pulse with *_data.
//
// Arbitration: MEM has priority over IF, even while its request is blocked.
//
// Optional feature (macro MEMCTRL_IO_STALL_EN): a MEM write at or above
// IO_BASE is held ungranted while io_buffer_full is high. Without the macro,
// io_buffer_full is ignored.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   if_req/if_addr       fetch byte-read request
//   if_grant             fetch request accepted this cycle (combinational)
//   if_data/_valid       fetch read byte and its one-cycle valid pulse
//   mem_req/mem_r_w      MEM byte request, 0 = read, 1 = write
//   mem_req_addr/_data   MEM address and write byte
//   mem_grant            MEM request accepted this cycle (combinational)
//   mem_data/_valid      MEM read byte and its one-cycle valid pulse
//   io_buffer_full       IO sink cannot take a byte
//   ram_din              RAM read data, valid the cycle after ram_a
//   ram_dout/ram_a/ram_wr registered RAM write data, address, write enable
module mem_ctrl #(
  parameter int          ADDR_W  = 32,
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_grant,
  output logic [7:0]        if_data,
  output logic              if_data_valid,
  input  logic              mem_req,
  input  logic              mem_r_w,
  input  logic [31:0]       mem_req_addr,
  input  logic [7:0]        mem_req_data,
  output logic              mem_grant,
  output logic [7:0]        mem_data,
  output logic              mem_data_valid,
  input  logic              io_buffer_full,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  logic   io_block;
  logic   tag1_valid;
  owner_t tag1_owner;
  logic   tag2_valid;
  owner_t tag2_owner;

`ifdef MEMCTRL_IO_STALL_EN
  // Only writes into the IO window stall; IO reads pass straight through.
  assign io_block = mem_r_w & (mem_req_addr >= IO_BASE) & io_buffer_full;
`else
  assign io_block = 1'b0;
`endif

  // Upper address bits are dropped when ADDR_W < 32, and io_buffer_full is
  // unused without the stall feature; fold them into one sink signal.
  logic unused_inputs;
  assign unused_inputs = ^{if_addr, mem_req_addr, io_buffer_full};

  // A blocked MEM request still keeps IF off the RAM.
  assign mem_grant = mem_req & ~io_block;
  assign if_grant  = if_req & ~mem_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_a          <= '0;
      ram_wr         <= 1'b0;
      ram_dout       <= 8'h00;
      tag1_valid     <= 1'b0;
      tag1_owner     <= OWN_IF;
      tag2_valid     <= 1'b0;
      tag2_owner     <= OWN_IF;
      if_data        <= 8'h00;
      if_data_valid  <= 1'b0;
      mem_data       <= 8'h00;
      mem_data_valid <= 1'b0;
    end else begin
      // RAM command stage: address and data hold when idle, write strobe drops.
      ram_wr <= 1'b0;
      if (mem_grant) begin
        ram_a  <= mem_req_addr[ADDR_W-1:0];
        ram_wr <= mem_r_w;
        if (mem_r_w) begin
          ram_dout <= mem_req_data;
        end
      end else if (if_grant) begin
        ram_a <= if_addr[ADDR_W-1:0];
      end

      // Tag stage 1 lines up with ram_a, stage 2 with ram_din.
      tag1_valid <= (mem_grant & ~mem_r_w) | if_grant;
      tag1_owner <= mem_grant ? OWN_MEM : OWN_IF;
      tag2_valid <= tag1_valid;
      tag2_owner <= tag1_owner;

      // Return stage: route ram_din to whoever owns the stage-2 tag.
      if_data_valid  <= tag2_valid & (tag2_owner == OWN_IF);
      mem_data_valid <= tag2_valid & (tag2_owner == OWN_MEM);
      if (tag2_valid && tag2_owner == OWN_IF) begin
        if_data <= ram_din;
      end
      if (tag2_valid && tag2_owner == OWN_MEM) begin
        mem_data <= ram_din;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_grant;
  logic [7:0]  if_data;
  logic        if_data_valid;
  logic        mem_req = 1'b0;
  logic        mem_r_w = 1'b0;
  logic [31:0] mem_req_addr = '0;
  logic [7:0]  mem_req_data = '0;
  logic        mem_grant;
  logic [7:0]  mem_data;
  logic        mem_data_valid;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  // Narrow-address instance, shares the request inputs.
  logic        if_grant17, if_data_valid17, mem_grant17, mem_data_valid17, ram_wr17;
  logic [7:0]  if_data17, mem_data17, ram_dout17;
  logic [16:0] ram_a17;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant),
    .if_data(if_data), .if_data_valid(if_data_valid),
    .mem_req(mem_req), .mem_r_w(mem_r_w), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_grant(mem_grant),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid),
    .io_buffer_full(io_buffer_full), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  mem_ctrl #(.ADDR_W(17)) dut17 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant17),
    .if_data(if_data17), .if_data_valid(if_data_valid17),
    .mem_req(mem_req), .mem_r_w(mem_r_w), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_grant(mem_grant17),
    .mem_data(mem_data17), .mem_data_valid(mem_data_valid17),
    .io_buffer_full(io_buffer_full), .ram_din(ram_din),
    .ram_dout(ram_dout17), .ram_a(ram_a17), .ram_wr(ram_wr17)
  );

  // ---------------- RAM model: synchronous read, one-cycle latency ----------------
  logic [7:0] ram_mem [0:4095];
  logic       preload_done = 1'b0;
  always @(posedge clk) begin
    if (!preload_done) begin
      for (int i = 0; i < 4096; i++) ram_mem[i] <= 8'h00;
      ram_mem[12'h100] <= 8'h5A;
      preload_done <= 1'b1;
    end else if (ram_wr) begin
      ram_mem[ram_a[11:0]] <= ram_dout;
    end
    ram_din <= ram_mem[ram_a[11:0]];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    if_req = 1'b0; mem_req = 1'b0; mem_r_w = 1'b0; io_buffer_full = 1'b0;
  endtask

  task automatic mem_cmd(input logic rw, input logic [31:0] a, input logic [7:0] d);
    mem_req = 1'b1; mem_r_w = rw; mem_req_addr = a; mem_req_data = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_data"}, if_data, 0);
    chk({tag, "_if_valid"}, if_data_valid, 0);
    chk({tag, "_mem_data"}, mem_data, 0);
    chk({tag, "_mem_valid"}, mem_data_valid, 0);
    chk({tag, "_ram_dout"}, ram_dout, 0);
    chk({tag, "_ram_a"}, ram_a, 0);
    chk({tag, "_ram_wr"}, ram_wr, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] wd [4];
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;

    // Reset: outputs at reset values, grants follow their equations.
    next_cycle();
    sample();
    chk_reset_outputs("rst");
    chk("rst_if_grant_idle", if_grant, 0);
    chk("rst_mem_grant_idle", mem_grant, 0);
    if_req = 1'b1; if_addr = 32'h0000_0123;
    #1;
    chk("rst_if_grant_eq", if_grant, 1);
    next_cycle();
    sample();
    chk("rst_ram_a_held", ram_a, 0);
    idle();
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // Test 1: single MEM read of preloaded 0x5A.
    for (int k = 0; k <= 4; k++) begin
      if (k == 0) mem_cmd(1'b0, 32'h100, 8'h00); else idle();
      sample();
      if (k == 0) begin
        chk("t1_mem_grant", mem_grant, 1);
        chk("t1_if_grant", if_grant, 0);
      end
      if (k == 1) begin
        chk("t1_ram_a", ram_a, 32'h100);
        chk("t1_ram_wr", ram_wr, 0);
      end
      chk("t1_mem_valid", mem_data_valid, (k == 3) ? 1 : 0);
      if (k == 3) chk("t1_mem_data", mem_data, 8'h5A);
      next_cycle();
    end

    // Test 2: four back-to-back writes then four back-to-back reads.
    for (int i = 0; i < 4; i++) exp_q.push_back(wd[i]);
    for (int k = 0; k <= 11; k++) begin
      if (k < 4) mem_cmd(1'b1, 32'h200 + k, wd[k]);
      else if (k < 8) mem_cmd(1'b0, 32'h200 + (k - 4), 8'h00);
      else idle();
      sample();
      if (k < 8) chk("t2_mem_grant", mem_grant, 1);
      if (k >= 1 && k <= 8) chk("t2_ram_a", ram_a, 32'h200 + ((k - 1) % 4));
      if (k >= 1 && k <= 4) begin
        chk("t2_ram_wr", ram_wr, 1);
        chk("t2_ram_dout", ram_dout, wd[k-1]);
      end
      if (k >= 5 && k <= 8) chk("t2_ram_rd", ram_wr, 0);
      chk("t2_if_valid", if_data_valid, 0);
      chk("t2_mem_valid", mem_data_valid, (k >= 7 && k <= 10) ? 1 : 0);
      if (mem_data_valid && exp_q.size() > 0) chk("t2_mem_data", mem_data, exp_q.pop_front());
      next_cycle();
    end
    chk("t2_drained", exp_q.size(), 0);

    // Test 3: simultaneous requests, MEM wins, IF follows without a bubble.
    for (int k = 0; k <= 5; k++) begin
      if (k == 0) begin
        mem_cmd(1'b0, 32'h200, 8'h00);
        if_req = 1'b1; if_addr = 32'h100;
      end else if (k == 1) begin
        mem_req = 1'b0;
      end else begin
        idle();
      end
      sample();
      if (k == 0) begin
        chk("t3_mem_grant", mem_grant, 1);
        chk("t3_if_grant_c0", if_grant, 0);
      end
      if (k == 1) chk("t3_if_grant_c1", if_grant, 1);
      if (k == 2) chk("t3_if_grant_c2", if_grant, 0);
      chk("t3_mem_valid", mem_data_valid, (k == 3) ? 1 : 0);
      chk("t3_if_valid", if_data_valid, (k == 4) ? 1 : 0);
      if (k == 3) chk("t3_mem_data", mem_data, 8'h11);
      if (k == 4) chk("t3_if_data", if_data, 8'h5A);
      next_cycle();
    end

    // Test 4: IO write with the sink full.
`ifdef MEMCTRL_IO_STALL_EN
    for (int k = 0; k <= 6; k++) begin
      if (k < 5) begin
        mem_cmd(1'b1, 32'h0003_0000, 8'h41); io_buffer_full = 1'b1;
      end else if (k == 5) begin
        io_buffer_full = 1'b0;
      end else begin
        idle();
      end
      sample();
      if (k < 5) chk("t4_blocked_grant", mem_grant, 0);
      if (k == 5) chk("t4_release_grant", mem_grant, 1);
      if (k >= 1 && k <= 5) chk("t4_blocked_wr", ram_wr, 0);
      if (k == 6) begin
        chk("t4_ram_wr", ram_wr, 1);
        chk("t4_ram_dout", ram_dout, 8'h41);
      end
      next_cycle();
    end
`else
    for (int k = 0; k <= 1; k++) begin
      if (k == 0) begin
        mem_cmd(1'b1, 32'h0003_0000, 8'h41); io_buffer_full = 1'b1;
      end else begin
        idle();
      end
      sample();
      if (k == 0) chk("t4_grant_c0", mem_grant, 1);
      if (k == 1) begin
        chk("t4_ram_wr", ram_wr, 1);
        chk("t4_ram_dout", ram_dout, 8'h41);
      end
      next_cycle();
    end
`endif
    // IO-window read is never blocked.
    mem_cmd(1'b0, 32'h0003_0004, 8'h00); io_buffer_full = 1'b1;
    sample();
    chk("t4_io_read_grant", mem_grant, 1);
    next_cycle();
    idle();
    for (int k = 0; k < 4; k++) next_cycle();

    // Test 5: reset in the middle of a read.
    for (int k = 0; k <= 5; k++) begin
      if (k == 0) mem_cmd(1'b0, 32'h100, 8'h00); else idle();
      if (k == 2) rst = 1'b0;
      if (k == 3) rst = 1'b1;
      sample();
      if (k == 2) chk_reset_outputs("t5_in_rst");
      if (k == 3) chk_reset_outputs("t5_after_rst");
      chk("t5_mem_valid", mem_data_valid, 0);
      chk("t5_if_valid", if_data_valid, 0);
      next_cycle();
    end

    // Test 6: address truncation on the 17-bit instance.
    mem_cmd(1'b0, 32'h0002_0005, 8'h00);
    next_cycle();
    idle();
    sample();
    chk("t6_ram_a17", ram_a17, 17'h00005);
    chk("t6_ram_a32", ram_a, 32'h0002_0005);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
